// File: rtl/bitstream_sync_checker_pkg.sv
// Shared types and constants for the bitstream framing/integrity stage.
// Header layout: length in bits[LEN_MSB:LEN_LSB], all bits above must be zero.
package bitstream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK
    } bs_state_e;

    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;
    localparam int          LEN_LSB           = 0;
    localparam int          LEN_MSB           = 15;

    // A header is legal when its upper half is clear and 1 <= N <= max_words.
    function automatic logic header_ok(input logic [31:0] hdr, input logic [15:0] max_words);
        logic [15:0] n;
        n = hdr[LEN_MSB:LEN_LSB];
        return (hdr[31:LEN_MSB+1] == '0) && (n != 16'd0) && (n <= max_words);
    endfunction

endpackage

// File: rtl/bitstream_sync_checker_if.sv
// Word stream in from the SPI mux and framed payload/status out to the fabric config logic.
// valid_i qualifies data_i for exactly one word per high cycle; there is no ready, the sink always accepts.
interface bitstream_sync_checker_if;
    logic [31:0] data_i;
    logic        valid_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic        ok_o;

    modport slave (
        input  data_i, valid_i,
        output data_o, valid_o, busy_o, done_o, error_o, ok_o
    );

    modport master (
        output data_i, valid_i,
        input  data_o, valid_o, busy_o, done_o, error_o, ok_o
    );
endinterface

// File: rtl/bitstream_sync_checker_checksum.sv
// 32-bit modulo-2^32 accumulator; shared with the readback path.
module bitstream_checksum (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        add_i,
    input  logic [31:0] word_i,
    output logic [31:0] sum_o
);
    logic [31:0] sum_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            sum_q <= '0;
        end else if (add_i) begin
            sum_q <= sum_q + word_i;
        end
    end

    assign sum_o = sum_q;
endmodule

// File: rtl/bitstream_sync_checker.sv
// Hunts for the sync word, reads the length header, forwards N payload words
// and validates the trailing checksum, pulsing done/error one cycle after the deciding word.
module bitstream_sync_checker
    import bitstream_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter logic [15:0] MAX_WORDS = 16'h1762
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    bitstream_sync_checker_if.slave   bus,
    output bs_state_e                 state_o
);
    bs_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        ok_q, ok_d;
    logic        sum_clear, sum_add;
    logic [31:0] sum;

    bitstream_checksum u_checksum (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (sum_clear),
        .add_i   (sum_add),
        .word_i  (bus.data_i),
        .sum_o   (sum)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            error_q <= error_d;
            ok_q    <= ok_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        ok_d      = ok_q;
        sum_clear = 1'b0;
        sum_add   = 1'b0;

        if (bus.valid_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.data_i == SYNC_WORD) begin
                        state_d = ST_LEN;
                        ok_d    = 1'b0;
                    end
                end
                ST_LEN: begin
                    if (header_ok(bus.data_i, MAX_WORDS)) begin
                        cnt_d     = bus.data_i[LEN_MSB:LEN_LSB];
                        sum_clear = 1'b1;
                        state_d   = ST_PAYLOAD;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                // Sync-valued words here are plain payload; only the count ends the frame.
                ST_PAYLOAD: begin
                    data_d  = bus.data_i;
                    valid_d = 1'b1;
                    sum_add = 1'b1;
                    cnt_d   = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (bus.data_i == sum) begin
                        done_d = 1'b1;
                        ok_d   = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = (state_q != ST_IDLE);
    assign bus.done_o  = done_q;
    assign bus.error_o = error_q;
    assign bus.ok_o    = ok_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_bitstream_sync_checker.sv
// Bench for bitstream_sync_checker: directed vector table, reset-mid-frame sequence,
// and randomized frames scored against a frame-level model.
module tb_bitstream_sync_checker;
    import bitstream_pkg::*;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
    localparam logic [15:0] MAXW = 16'h1762;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    bs_state_e state;

    bitstream_sync_checker_if bus ();

    bitstream_sync_checker #(.SYNC_WORD(SYNC), .MAX_WORDS(MAXW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus),
        .state_o (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic        mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input int max_gap);
        int gaps;
        gaps = $urandom_range(0, max_gap);
        repeat (gaps) begin
            bus.valid_i = 1'b0;
            tick();
        end
        bus.valid_i = 1'b1;
        bus.data_i  = w;
        tick();
        bus.valid_i = 1'b0;
    endtask

    // Forwarded-word scoreboard: every valid_o beat must match the head of exp_q.
    always @(negedge clk) begin
        if (mon_en && bus.valid_o) begin
            if (exp_q.size() == 0) begin
                check("fwd_extra", {32'd0, bus.data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("fwd_word", {32'd0, bus.data_o}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
        logic        e_ok;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic v, input logic [31:0] d, input logic e_valid,
                           input logic [31:0] e_data, input logic e_busy, input logic e_done,
                           input logic e_err, input logic e_ok);
        vec_t r;
        r.v = v; r.d = d; r.e_valid = e_valid; r.e_data = e_data;
        r.e_busy = e_busy; r.e_done = e_done; r.e_err = e_err; r.e_ok = e_ok;
        vecs.push_back(r);
    endtask

    function automatic logic [63:0] outs();
        return {27'd0, bus.valid_o, bus.data_o, bus.busy_o, bus.done_o, bus.error_o, bus.ok_o};
    endfunction

    initial begin
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_outs", outs(), 64'd0);
        check("reset_state", {62'd0, state}, {62'd0, ST_IDLE});

        //      v  data          vo dout          busy done err ok
        add_vec(1, 32'h1234,     0, 32'h0,        0, 0, 0, 0);
        add_vec(1, 32'hDEAD,     0, 32'h0,        0, 0, 0, 0);
        add_vec(1, SYNC,         0, 32'h0,        1, 0, 0, 0);
        add_vec(0, 32'h0,        0, 32'h0,        1, 0, 0, 0);
        add_vec(1, 32'd3,        0, 32'h0,        1, 0, 0, 0);
        add_vec(1, 32'd1,        1, 32'd1,        1, 0, 0, 0);
        add_vec(1, 32'd2,        1, 32'd2,        1, 0, 0, 0);
        add_vec(0, 32'h0,        0, 32'd2,        1, 0, 0, 0);
        add_vec(1, 32'd3,        1, 32'd3,        1, 0, 0, 0);
        add_vec(1, 32'd6,        0, 32'd3,        0, 1, 0, 1);
        add_vec(1, SYNC,         0, 32'd3,        1, 0, 0, 0);
        add_vec(1, 32'd0,        0, 32'd3,        0, 0, 1, 0);
        add_vec(1, SYNC,         0, 32'd3,        1, 0, 0, 0);
        add_vec(1, 32'h1763,     0, 32'd3,        0, 0, 1, 0);
        add_vec(1, SYNC,         0, 32'd3,        1, 0, 0, 0);
        add_vec(1, 32'h0001_0002,0, 32'd3,        0, 0, 1, 0);
        add_vec(1, SYNC,         0, 32'd3,        1, 0, 0, 0);
        add_vec(1, 32'd2,        0, 32'd3,        1, 0, 0, 0);
        add_vec(1, 32'hFFFF_FFFF,1, 32'hFFFF_FFFF,1, 0, 0, 0);
        add_vec(1, 32'd2,        1, 32'd2,        1, 0, 0, 0);
        add_vec(1, 32'd1,        0, 32'd2,        0, 1, 0, 1);
        add_vec(1, SYNC,         0, 32'd2,        1, 0, 0, 0);
        add_vec(1, 32'd2,        0, 32'd2,        1, 0, 0, 0);
        add_vec(1, 32'hFFFF_FFFF,1, 32'hFFFF_FFFF,1, 0, 0, 0);
        add_vec(1, 32'd2,        1, 32'd2,        1, 0, 0, 0);
        add_vec(1, 32'd0,        0, 32'd2,        0, 0, 1, 0);
        add_vec(1, SYNC,         0, 32'd2,        1, 0, 0, 0);
        add_vec(1, 32'd1,        0, 32'd2,        1, 0, 0, 0);
        add_vec(1, SYNC,         1, SYNC,         1, 0, 0, 0);
        add_vec(1, SYNC,         0, SYNC,         0, 1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.valid_i = vecs[i].v;
            bus.data_i  = vecs[i].d;
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {27'd0, vecs[i].e_valid, vecs[i].e_data, vecs[i].e_busy,
                   vecs[i].e_done, vecs[i].e_err, vecs[i].e_ok});
        end
        bus.valid_i = 1'b0;

        // Reset after 2 of 5 payload words, then a complete frame.
        send(SYNC, 0);
        send(32'd5, 0);
        send(32'h11, 0);
        send(32'h22, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_outs", outs(), 64'd0);
        check("midreset_state", {62'd0, state}, {62'd0, ST_IDLE});
        tick();
        check("midreset_quiet", outs(), 64'd0);
        send(SYNC, 0);
        send(32'd3, 0);
        send(32'd10, 0);
        check("post_rst_w0", {32'd0, bus.data_o}, 64'd10);
        send(32'd20, 0);
        send(32'd30, 0);
        check("post_rst_w2", {32'd0, bus.data_o}, 64'd30);
        send(32'd60, 0);
        check("post_rst_done", {60'd0, bus.done_o, bus.error_o, bus.ok_o, bus.busy_o}, 64'b1010);

        // Randomized frames against a frame-level model.
        mon_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int          n_garbage;
            int          kind;
            logic [31:0] hdr;
            logic [31:0] sum;
            logic        good_hdr;
            logic        good_sum;
            n_garbage = $urandom_range(0, 3);
            for (int g = 0; g < n_garbage; g++) begin
                logic [31:0] w;
                w = $urandom();
                if (w == SYNC) w = 32'h0;
                send(w, 2);
            end
            send(SYNC, 2);
            kind = $urandom_range(0, 9);
            good_hdr = 1'b0;
            case (kind)
                0: hdr = 32'd0;
                1: hdr = {16'd0, MAXW + 16'($urandom_range(1, 100))};
                2: hdr = {16'($urandom_range(1, 16'hFFFF)), 16'($urandom_range(1, 8))};
                default: begin
                    hdr = 32'($urandom_range(1, 8));
                    good_hdr = 1'b1;
                end
            endcase
            send(hdr, 2);
            good_sum = 1'b0;
            if (good_hdr) begin
                sum = 32'd0;
                for (int k = 0; k < int'(hdr); k++) begin
                    logic [31:0] w;
                    w = ($urandom_range(0, 3) == 0) ? SYNC : 32'($urandom());
                    sum = sum + w;
                    exp_q.push_back(w);
                    send(w, 2);
                end
                good_sum = ($urandom_range(0, 3) != 0);
                send(good_sum ? sum : sum + 32'd1, 2);
            end
            check($sformatf("frame%0d_status", f),
                  {60'd0, bus.done_o, bus.error_o, bus.ok_o, bus.busy_o},
                  {60'd0, good_sum, !good_sum, good_sum, 1'b0});
        end
        repeat (2) tick();
        mon_en = 1'b0;
        check("fwd_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
